// File: rtl/tile_chk_pkg.sv
// tile_chk_pkg: FSM states and MISR constants shared by the tile stimulus checker.
package tile_chk_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'h0000;
endpackage

// File: rtl/tile_chk_misr.sv
// tile_chk_misr: 16-bit MISR (x^16+x^12+x^5+1) with synchronous clear and update enable.
module tile_chk_misr
  import tile_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] data,
  output logic [15:0] sig
);
  always_ff @(posedge clk)
    if (rst || clr) sig <= MISR_SEED;
    else if (en) sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ data;
endmodule

// File: rtl/tile_stim_checker.sv
// tile_stim_checker: sweeps ui_in over 0..VEC_LAST, compares uo_out against exp_out after a settle time.
// Define TILE_CHK_SIG_EN to add a MISR signature over the sampled uo_out values.
module tile_stim_checker
  import tile_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int VEC_LAST      = 255,
  parameter int ERR_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [7:0]       ui_in,
  input  logic [7:0]       uo_out,
  input  logic [7:0]       exp_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       first_fail_vec,
  output logic [7:0]       first_fail_got
`ifdef TILE_CHK_SIG_EN
  ,
  output logic [15:0]      signature
`endif
);
  state_t state, state_n;
  logic [7:0] vec;
  logic [15:0] cnt;
  logic acc, samp, last, mis;
  assign acc  = start && (state == IDLE || state == DONE);
  assign samp = state == SAMPLE;
  assign last = vec == 8'(VEC_LAST);
  assign mis  = uo_out != exp_out;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = acc ? DRIVE
            : state == DRIVE  ? SETTLE
            : state == SETTLE ? (cnt == 16'(SETTLE_CYCLES - 1) ? SAMPLE : SETTLE)
            : state == SAMPLE ? (last ? DONE : DRIVE)
            : state;
  end
  always_comb begin
    busy = state == DRIVE || state == SETTLE || state == SAMPLE;
    done = state == DONE;
    pass = done && err_cnt == '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      ui_in          <= '0;
      vec            <= '0;
      cnt            <= '0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
      first_fail_got <= '0;
    end else begin
      if (acc) begin
        vec            <= '0;
        err_cnt        <= '0;
        first_fail_vec <= '0;
        first_fail_got <= '0;
      end
      if (state == DRIVE) begin
        ui_in <= vec;
        cnt   <= '0;
      end
      if (state == SETTLE) cnt <= cnt + 16'd1;
      if (samp) begin
        if (mis && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (mis && err_cnt == '0) begin
          first_fail_vec <= vec;
          first_fail_got <= uo_out;
        end
        if (!last) vec <= vec + 8'd1;
      end
    end
`ifdef TILE_CHK_SIG_EN
  tile_chk_misr u_misr (
    .clk (clk),
    .rst (rst),
    .en  (samp),
    .clr (acc),
    .data({8'h00, uo_out}),
    .sig (signature)
  );
`endif
endmodule

// File: tb/tb_tile_stim_checker.sv
// tb_tile_stim_checker: scoreboard bench for tile_stim_checker with fault-injecting tile models.
module tb_tile_stim_checker;
  logic clk = 0, rst = 1, start = 0;
  int mode = 0;
  logic [7:0] ui_in, uo_out, ui4, uo4;
  logic busy, done, pass, busy4, done4, pass4;
  logic [15:0] err_cnt;
  logic [3:0] err4;
  logic [7:0] ffv, ffg, ffv4, ffg4;
`ifdef TILE_CHK_SIG_EN
  logic [15:0] sig, sig4;
`endif
  int n_chk = 0, n_fail = 0;
  typedef struct {
    int          err;
    logic [7:0]  ffv;
    logic [7:0]  ffg;
    logic [15:0] sig;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  function automatic logic [7:0] tile(int m, logic [7:0] v);
    return m == 0 ? v : m == 1 ? (v == 8'h05 ? (v & 8'hFE) : v) : ~v;
  endfunction
  assign uo_out = tile(mode, ui_in);
  assign uo4    = tile(mode, ui4);
  tile_stim_checker dut (
    .clk(clk), .rst(rst), .start(start), .ui_in(ui_in), .uo_out(uo_out), .exp_out(ui_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_vec(ffv), .first_fail_got(ffg)
`ifdef TILE_CHK_SIG_EN
    , .signature(sig)
`endif
  );
  tile_stim_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .ui_in(ui4), .uo_out(uo4), .exp_out(ui4),
    .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4),
    .first_fail_vec(ffv4), .first_fail_got(ffg4)
`ifdef TILE_CHK_SIG_EN
    , .signature(sig4)
`endif
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(int m);
    exp_t e;
    logic [7:0] g;
    e.err = 0; e.ffv = 0; e.ffg = 0; e.sig = 16'h0000;
    for (int v = 0; v < 256; v++) begin
      g = tile(m, 8'(v));
      if (g != 8'(v)) begin
        if (e.err == 0) begin e.ffv = 8'(v); e.ffg = g; end
        e.err++;
      end
      e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h1021 : 16'h0000) ^ {8'h00, g};
    end
    return e;
  endfunction
  task automatic check_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_ui"}, ui_in, 0);
    chk({tag, "_ffv"}, ffv, 0);
    chk({tag, "_ffg"}, ffg, 0);
    chk({tag, "_err4"}, err4, 0);
`ifdef TILE_CHK_SIG_EN
    chk({tag, "_sig"}, sig, 0);
`endif
  endtask
  task automatic run(int m, bit mid);
    exp_t e;
    int cyc = 0;
    mode = m;
    sb.push_back(model(m));
    start = 1;
    while (!done || cyc < 2) begin
      @(posedge clk);
      #1;
      cyc++;
      start = mid && cyc == 100;
      if (cyc == 1) begin
        chk("acc_busy", busy, 1);
        chk("acc_done", done, 0);
        chk("acc_err", err_cnt, 0);
      end
      if (cyc > 2000) break;
    end
    chk("done_cycles", cyc, 1025);
    e = sb.pop_front();
    chk("err_cnt", err_cnt, e.err > 65535 ? 65535 : e.err);
    chk("err_cnt4", err4, e.err > 15 ? 15 : e.err);
    chk("pass", pass, e.err == 0);
    chk("busy_end", busy, 0);
    chk("ui_last", ui_in, 8'hFF);
    if (e.err != 0) begin
      chk("ffv", ffv, e.ffv);
      chk("ffg", ffg, e.ffg);
    end
`ifdef TILE_CHK_SIG_EN
    chk("signature", sig, e.sig);
    repeat (3) @(posedge clk);
    #1 chk("sig_frozen", sig, e.sig);
`endif
  endtask
  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst = 0;
    run(0, 0);
    run(1, 0);
    run(2, 1);
    run(0, 0);
    mode = 0;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    cyc = 0;
    while (ui_in != 8'h40 && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("reach_40", ui_in, 8'h40);
    rst = 1;
    @(posedge clk);
    #1 check_zero("mid_rst");
    rst = 0;
    run(0, 0);
    rst = 1;
    start = 1;
    @(posedge clk);
    #1 check_zero("rst_start");
    rst = 0;
    start = 0;
    @(posedge clk);
    #1 chk("idle_after_rst", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
